// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux41 select arbiter: state encoding, channel
// count, dwell-counter width and a one-hot helper.
package mux_sel_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational circular-priority picker: the first set request bit found when
// scanning from ptr+1 upward, wrapping modulo four.
module rr_pick
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [1:0]        pick,
    output logic              any_req
);

    logic [1:0] idx;
    logic       found;

    assign any_req = |req;

    // The channel at ptr itself is checked last, so it gets the lowest priority.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives a mux41 select. Each grant lasts up to DWELL
// cycles and is always followed by at least one idle cycle.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int NCH   = NUM_CH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    output logic [1:0]     sel,
    output logic           grant_valid,
    output logic [NCH-1:0] grant,
    output logic           grant_done
);

    arb_state_e       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pick;
    logic             any_req;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    // ptr resets to 3 so the first arbitration after reset starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b11;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    ptr_d   = pick;
                    cnt_d   = CNT_W'(DWELL - 1);
                end
            end
            GRANT: begin
                // A withdrawn request ends the grant just like an expired dwell.
                grant_done = (cnt_q == '0) || !req[sel_q];
                if (grant_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign sel         = sel_q;
    assign grant_valid = (state_q == GRANT);
    assign grant       = grant_valid ? onehot4(sel_q) : '0;

endmodule
